alu_arbiter: RTL and testbench

Sequencing and arbitration controller that shares the single `alu` datapath between two requesters. It accepts operation requests over valid/ready handshakes and picks between simultaneous requests. It generates a clean registered `enable` pulse with operands held stable around the rising edge, captures the result and flags, and returns them to the originating requester over a response handshake. It sits between the instruction-issue logic (requester 0) and the address/auxiliary unit (requester 1), and the `alu` instance.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu.sv | 66 ++++++
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its arbiter.
// Covers op codes, FSM states and requester port indices.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FIRE,
    CAPT,
    RESP
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/alu.sv
// Signed N-bit ALU that registers its result and flags on a clock edge where enable is high.
// Any op code above XOR is treated as a signed multiply truncated to N bits.
module alu
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [2:0]   control,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] dOut,
  output logic         overflow,
  output logic         zero,
  output logic         negative
);

  logic [N-1:0]          sum;
  logic [N-1:0]          diff;
  logic [N-1:0]          res;
  logic signed [2*N-1:0] prod;
  logic                  ovf;

  always_comb begin
    sum  = a + b;
    diff = a - b;
    prod = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
    res  = '0;
    ovf  = 1'b0;
    case (control)
      OP_ADD: begin
        res = sum;
        ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      default: begin
        // Product fits only if the upper half is a pure sign extension of bit N-1.
        res = prod[N-1:0];
        ovf = !((&prod[2*N-1:N-1]) || !(|prod[2*N-1:N-1]));
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dOut     <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else if (enable) begin
      dOut     <= res;
      overflow <= ovf;
      zero     <= (res == '0);
      negative <= res[N-1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu between two requesters: arbitrate, sequence enable, return result.
// Define ALU_ARB_RR_EN for round-robin ties; otherwise port 0 always wins a tie.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_overflow,
  output logic         rsp_zero,
  output logic         rsp_negative,
  output logic         busy
);

  state_t       state, next_state;
  logic         grant;
  logic         pick;
  logic         accept;
  logic [2:0]   op_r;
  logic [N-1:0] a_r, b_r;
  logic [2:0]   alu_control;
  logic [N-1:0] alu_a, alu_b;
  logic         alu_enable;
  logic [N-1:0] alu_dout;
  logic         alu_ovf, alu_zero, alu_neg;

`ifdef ALU_ARB_RR_EN
  logic last_grant;

  // On a tie, hand the grant to whichever port did not get the previous one.
  always_comb pick = req1_valid && (!req0_valid || (last_grant == PORT0));
`else
  always_comb pick = req1_valid && !req0_valid;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid && (pick == PORT0);
        req1_ready = req1_valid && (pick == PORT1);
        accept     = (req0_valid && (pick == PORT0)) || (req1_valid && (pick == PORT1));
        if (accept) next_state = SETUP;
      end
      SETUP: next_state = FIRE;
      FIRE:  next_state = CAPT;
      CAPT:  next_state = RESP;
      RESP: begin
        if ((grant == PORT0 && rsp0_ready) || (grant == PORT1 && rsp1_ready))
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign rsp0_valid = (state == RESP) && (grant == PORT0);
  assign rsp1_valid = (state == RESP) && (grant == PORT1);
  assign busy       = (state != IDLE);

  // Enable is registered off SETUP so it is a clean one-cycle pulse covering FIRE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant        <= PORT0;
      op_r         <= '0;
      a_r          <= '0;
      b_r          <= '0;
      alu_control  <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_enable   <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_negative <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_grant   <= PORT1;
`endif
    end else begin
      alu_enable <= (state == SETUP);
      if (accept) begin
        grant <= pick;
        op_r  <= (pick == PORT1) ? req1_op : req0_op;
        a_r   <= (pick == PORT1) ? req1_a  : req0_a;
        b_r   <= (pick == PORT1) ? req1_b  : req0_b;
`ifdef ALU_ARB_RR_EN
        last_grant <= pick;
`endif
      end
      if (state == SETUP) begin
        alu_control <= op_r;
        alu_a       <= a_r;
        alu_b       <= b_r;
      end
      if (state == CAPT) begin
        rsp_result   <= alu_dout;
        rsp_overflow <= alu_ovf;
        rsp_zero     <= alu_zero;
        rsp_negative <= alu_neg;
      end
    end
  end

  alu #(.N(N)) u_alu (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (alu_enable),
    .control  (alu_control),
    .a        (alu_a),
    .b        (alu_b),
    .dOut     (alu_dout),
    .overflow (alu_ovf),
    .zero     (alu_zero),
    .negative (alu_neg)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level reference model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [N-1:0] rsp_result;
  logic         rsp_overflow, rsp_zero, rsp_negative, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_op      (req0_op),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_op      (req1_op),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .rsp0_valid   (rsp0_valid),
    .rsp0_ready   (rsp0_ready),
    .rsp1_valid   (rsp1_valid),
    .rsp1_ready   (rsp1_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .rsp_negative (rsp_negative),
    .busy         (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic done with wide integers and range checks.
  function automatic void model_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic ov, output logic z, output logic ng);
    longint sa, sb, full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    case (op)
      OP_ADD:  full = sa + sb;
      OP_SUB:  full = sa - sb;
      OP_AND:  full = longint'(a & b);
      OP_OR:   full = longint'(a | b);
      OP_XOR:  full = longint'(a ^ b);
      default: full = sa * sb;
    endcase
    r = full[15:0];
    if (op == OP_ADD || op == OP_SUB || op > OP_XOR)
      ov = (full > 32767) || (full < -32768);
    z  = (r == 16'h0000);
    ng = r[15];
  endfunction

  // Transaction model: one op in flight, response 3 edges after accept.
  bit          m_pend = 1'b0;
  bit          m_port = 1'b0;
  int          m_cnt = 0;
  logic [2:0]  m_op;
  logic [15:0] m_a, m_b;
  logic [15:0] m_res = '0;
  logic        m_ov = 1'b0, m_z = 1'b0, m_ng = 1'b0;
`ifdef ALU_ARB_RR_EN
  bit          m_last = 1'b1;
`endif

  function automatic bit pick_port(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
      return (m_last == 1'b1) ? 1'b0 : 1'b1;
`else
      return 1'b0;
`endif
    end
    return v1;
  endfunction

  always @(posedge clk) begin : model
    bit p;
    if (!rst_n) begin
      m_pend = 1'b0;
      m_cnt  = 0;
      m_res  = '0;
      m_ov   = 1'b0;
      m_z    = 1'b0;
      m_ng   = 1'b0;
`ifdef ALU_ARB_RR_EN
      m_last = 1'b1;
`endif
    end else if (!m_pend) begin
      p = pick_port(req0_valid, req1_valid);
      if (p ? req1_valid : req0_valid) begin
        m_pend = 1'b1;
        m_port = p;
        m_cnt  = 0;
        m_op   = p ? req1_op : req0_op;
        m_a    = p ? req1_a : req0_a;
        m_b    = p ? req1_b : req0_b;
`ifdef ALU_ARB_RR_EN
        m_last = p;
`endif
      end
    end else if (m_cnt < 3) begin
      if (m_cnt == 2) model_alu(m_op, m_a, m_b, m_res, m_ov, m_z, m_ng);
      m_cnt++;
    end else if (m_port ? rsp1_ready : rsp0_ready) begin
      m_pend = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    bit p;
    if (chk_en) begin
      p = pick_port(req0_valid, req1_valid);
      checkOutput("req0_ready", req0_ready, !m_pend && req0_valid && !p);
      checkOutput("req1_ready", req1_ready, !m_pend && req1_valid && p);
      checkOutput("rsp0_valid", rsp0_valid, m_pend && m_cnt == 3 && !m_port);
      checkOutput("rsp1_valid", rsp1_valid, m_pend && m_cnt == 3 && m_port);
      checkOutput("busy", busy, m_pend);
      checkOutput("alu_enable", dut.alu_enable, m_pend && m_cnt == 1);
      checkOutput("rsp_result", rsp_result, m_res);
      checkOutput("rsp_flags", {rsp_overflow, rsp_zero, rsp_negative}, {m_ov, m_z, m_ng});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit port, input logic [2:0] op, input logic [15:0] a,
                               input logic [15:0] b, output int acc_cyc);
    bit done = 1'b0;
    acc_cyc = -1;
    if (port) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else      begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (port ? req1_ready : req0_ready) done = 1'b1;
      tick();
      if (done) acc_cyc = cyc;
    end
    if (port) req1_valid = 1'b0;
    else      req0_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitResponse(input bit port, output logic [15:0] r, output logic ov, output logic z,
                              output logic ng, output logic other, output int rsp_cyc);
    bit found = 1'b0;
    rsp_cyc = -1;
    {r, ov, z, ng, other} = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (port ? rsp1_valid : rsp0_valid) begin
        found = 1'b1;
        r = rsp_result; ov = rsp_overflow; z = rsp_zero; ng = rsp_negative;
        other = port ? rsp0_valid : rsp1_valid;
        rsp_cyc = cyc;
      end
      tick();
    end
    if (!found) checkOutput("response_timeout", 0, 1);
  endtask

  initial begin
    logic [15:0] r;
    logic        ov, z, ng, other;
    int          ca, cr, ca2;
    bit          g[4];
    bit          found;

    req0_valid = 0; req1_valid = 0;
    req0_op = '0; req1_op = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1; rsp1_ready = 1;

    rst_n = 0;
    tick();
    chk_en = 1'b1;
    tick();
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_result", rsp_result, 0);
    checkOutput("reset_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    checkOutput("reset_enable", dut.alu_enable, 0);
    rst_n = 1;
    tick();

    $display("[TB] port 0 ADD overflow");
    applyStimulus(1'b0, OP_ADD, 16'h7FFF, 16'h0001, ca);
    waitResponse(1'b0, r, ov, z, ng, other, cr);
    checkOutput("add_latency", cr - ca, 3);
    checkOutput("add_result", r, 16'h8000);
    checkOutput("add_flags", {ov, z, ng}, 3'b101);

    $display("[TB] port 1 SUB zero");
    applyStimulus(1'b1, OP_SUB, 16'd5, 16'd5, ca);
    waitResponse(1'b1, r, ov, z, ng, other, cr);
    checkOutput("sub_result", r, 16'h0000);
    checkOutput("sub_flags", {ov, z, ng}, 3'b010);
    checkOutput("sub_rsp0_quiet", other, 0);

    $display("[TB] back-to-back AND/OR");
    applyStimulus(1'b0, OP_AND, 16'h00FF, 16'h0F0F, ca);
    waitResponse(1'b0, r, ov, z, ng, other, cr);
    checkOutput("and_result", r, 16'h000F);
    applyStimulus(1'b0, OP_OR, 16'h00F0, 16'h0F00, ca2);
    waitResponse(1'b0, r, ov, z, ng, other, cr);
    checkOutput("or_result", r, 16'h0FF0);
    checkOutput("issue_interval", ca2 - ca, 5);

    $display("[TB] MUL with response backpressure");
    rsp0_ready = 0;
    applyStimulus(1'b0, 3'b110, 16'd3, 16'd7, ca);
    req1_valid = 1; req1_op = OP_ADD; req1_a = 16'd0; req1_b = 16'd0;
    waitResponse(1'b0, r, ov, z, ng, other, cr);
    checkOutput("mul_result", r, 16'd21);
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("hold_rsp0_valid", rsp0_valid, 1);
      checkOutput("hold_result", rsp_result, 16'd21);
      checkOutput("hold_ready", {req0_ready, req1_ready}, 2'b00);
      tick();
    end
    rsp0_ready = 1;
    tick();
    #1;
    checkOutput("idle_after_handshake", busy, 0);
    checkOutput("req1_ready_in_idle", req1_ready, 1);
    req1_valid = 0;
    tick();

    $display("[TB] reset during FIRE");
    applyStimulus(1'b0, OP_ADD, 16'd1, 16'd2, ca);
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_enable", dut.alu_enable, 0);
    checkOutput("abort_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    checkOutput("abort_result", rsp_result, 0);
    checkOutput("abort_flags", {rsp_overflow, rsp_zero, rsp_negative}, 0);
    tick();
    applyStimulus(1'b0, OP_ADD, 16'd2, 16'd3, ca);
    waitResponse(1'b0, r, ov, z, ng, other, cr);
    checkOutput("post_abort_result", r, 16'd5);
    checkOutput("post_abort_latency", cr - ca, 3);

    $display("[TB] arbitration with both ports valid");
    rst_n = 0;
    tick();
    rst_n = 1;
    req0_valid = 1; req0_op = OP_ADD; req0_a = 16'd1; req0_b = 16'd1;
    req1_valid = 1; req1_op = OP_ADD; req1_a = 16'd2; req1_b = 16'd2;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      g[k] = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        #1;
        if (req0_ready || req1_ready) begin
          found = 1'b1;
          g[k] = req1_ready;
        end
        tick();
      end
      if (!found) checkOutput("grant_timeout", 0, 1);
    end
`ifdef ALU_ARB_RR_EN
    checkOutput("grant_sequence", {g[0], g[1], g[2], g[3]}, 4'b0101);
`else
    checkOutput("grant_sequence", {g[0], g[1], g[2], g[3]}, 4'b0000);
`endif
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 20 && busy; i++) tick();

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 249) != 0);
      req0_valid = $urandom_range(0, 1);
      req1_valid = $urandom_range(0, 1);
      req0_op    = 3'($urandom);
      req1_op    = 3'($urandom);
      req0_a     = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
      req0_b     = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      req1_a     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      req1_b     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst_n = 1; req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (10) tick();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
